// File: rtl/msrv32_pkg.sv
// Shared msrv32 encodings and types used by the memory-stage store path.
// Holds store widths, AHB transfer types and the registered store-bus bundle.
package msrv32_pkg;

    localparam logic [1:0] FUNCT3_SB = 2'b00;
    localparam logic [1:0] FUNCT3_SH = 2'b01;
    localparam logic [1:0] FUNCT3_SW = 2'b10;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_NONSEQ = 2'b10
    } htrans_e;

    // Everything presented on the data bus during one AHB address phase.
    typedef struct packed {
        logic [31:0] d_addr;
        logic [31:0] data;
        logic [3:0]  wr_mask;
        htrans_e     htrans;
        logic        wr_req;
    } store_bus_t;

    localparam store_bus_t STORE_BUS_RESET = '{
        d_addr:  32'h0,
        data:    32'h0,
        wr_mask: 4'h0,
        htrans:  HTRANS_IDLE,
        wr_req:  1'b0
    };

    function automatic logic [31:0] word_align(input logic [31:0] byte_addr);
        return {byte_addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/msrv32_store_unit_if.sv
// Store request from the core and the registered AHB-side result of the store unit.
// master = core/testbench side, slave = the store unit itself.
interface msrv32_store_unit_if;
    logic [1:0]  funct3_in;
    logic [31:0] iadder_in;
    logic [31:0] rs2_in;
    logic        mem_wr_req_in;
    logic        ahb_ready_in;
    logic [31:0] d_addr_out;
    logic [31:0] data_out;
    logic [3:0]  wr_mask_out;
    logic [1:0]  ahb_htrans_out;
    logic        wr_req_out;

    modport master (
        output funct3_in, iadder_in, rs2_in, mem_wr_req_in, ahb_ready_in,
        input  d_addr_out, data_out, wr_mask_out, ahb_htrans_out, wr_req_out
    );

    modport slave (
        input  funct3_in, iadder_in, rs2_in, mem_wr_req_in, ahb_ready_in,
        output d_addr_out, data_out, wr_mask_out, ahb_htrans_out, wr_req_out
    );
endinterface

// File: rtl/msrv32_store_align.sv
// Steers store data into byte lanes and builds the byte write mask.
// Latency: combinational. Backpressure: none, pure function of its inputs.
module msrv32_store_align
    import msrv32_pkg::*;
(
    input  logic [1:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] rs2,
    output logic [31:0] data,
    output logic [3:0]  mask
);

    always_comb begin
        data = 32'h0;
        mask = 4'h0;
        case (funct3)
            FUNCT3_SB: begin
                data = {24'h0, rs2[7:0]} << {off, 3'b000};
                mask = 4'b0001 << off;
            end
            // Halfword offset bit 0 is ignored; misalignment is trapped elsewhere.
            FUNCT3_SH: begin
                if (off[1]) begin
                    data = {rs2[15:0], 16'h0};
                    mask = 4'b1100;
                end else begin
                    data = {16'h0, rs2[15:0]};
                    mask = 4'b0011;
                end
            end
            default: begin
                data = rs2;
                mask = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/msrv32_store_unit.sv
// Memory-stage store path: aligned address, lane-steered data, mask and HTRANS.
// Latency: 1 cycle. Backpressure: outputs hold while ahb_ready_in is low.
module msrv32_store_unit
    import msrv32_pkg::*;
(
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    msrv32_store_unit_if.slave    bus
);

    logic [31:0] align_data;
    logic [3:0]  align_mask;
    store_bus_t  next_bus;
    store_bus_t  bus_d;
    store_bus_t  bus_q;

    msrv32_store_align u_align (
        .funct3 (bus.funct3_in),
        .off    (bus.iadder_in[1:0]),
        .rs2    (bus.rs2_in),
        .data   (align_data),
        .mask   (align_mask)
    );

    // Data and mask are registered even without a request; wr_req/htrans qualify them.
    always_comb begin
        next_bus         = STORE_BUS_RESET;
        next_bus.d_addr  = word_align(bus.iadder_in);
        next_bus.data    = align_data;
        next_bus.wr_mask = align_mask;
        next_bus.htrans  = bus.mem_wr_req_in ? HTRANS_NONSEQ : HTRANS_IDLE;
        next_bus.wr_req  = bus.mem_wr_req_in;
    end

    // An AHB wait state must keep the address phase stable.
    always_comb begin
        bus_d = bus_q;
        if (bus.ahb_ready_in) begin
            bus_d = next_bus;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bus_q <= STORE_BUS_RESET;
        end else begin
            bus_q <= bus_d;
        end
    end

    assign bus.d_addr_out     = bus_q.d_addr;
    assign bus.data_out       = bus_q.data;
    assign bus.wr_mask_out    = bus_q.wr_mask;
    assign bus.ahb_htrans_out = bus_q.htrans;
    assign bus.wr_req_out     = bus_q.wr_req;

endmodule

// File: tb/tb_msrv32_store_unit.sv
// Self-checking bench for msrv32_store_unit: directed vector table, stall/reset
// sequences, and randomized traffic against a behavioural model.
module tb_msrv32_store_unit;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic [1:0]  htrans;
        logic        wr;
    } out_t;

    typedef struct {
        string       name;
        logic [1:0]  f3;
        logic [31:0] iadder;
        logic [31:0] rs2;
        logic        req;
        out_t        exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    msrv32_store_unit_if bus ();

    msrv32_store_unit dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t zero_out();
        out_t o;
        o = '0;
        return o;
    endfunction

    // Reference behaviour from the store rules, using plain shift arithmetic.
    function automatic out_t model(input logic [1:0] f3, input logic [31:0] iadder,
                                   input logic [31:0] rs2, input logic req);
        out_t o;
        int   off;
        int   m;
        off      = int'(iadder[1:0]);
        o.addr   = iadder - 32'(off);
        if (f3 == 2'd0) begin
            o.data = (rs2 & 32'hFF) << (8 * off);
            m      = 1 << off;
        end else if (f3 == 2'd1) begin
            o.data = (rs2 & 32'hFFFF) << (16 * (off / 2));
            m      = 3 << (2 * (off / 2));
        end else begin
            o.data = rs2;
            m      = 15;
        end
        o.mask   = m[3:0];
        o.htrans = req ? 2'd2 : 2'd0;
        o.wr     = req;
        return o;
    endfunction

    function automatic out_t actual();
        out_t o;
        o.addr   = bus.d_addr_out;
        o.data   = bus.data_out;
        o.mask   = bus.wr_mask_out;
        o.htrans = bus.ahb_htrans_out;
        o.wr     = bus.wr_req_out;
        return o;
    endfunction

    task automatic check(input string name, input out_t exp);
        out_t act;
        act = actual();
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got addr=%h data=%h mask=%b htrans=%b wr=%b, want addr=%h data=%h mask=%b htrans=%b wr=%b",
                     name, act.addr, act.data, act.mask, act.htrans, act.wr,
                     exp.addr, exp.data, exp.mask, exp.htrans, exp.wr);
        end
    endtask

    task automatic drive(input logic [1:0] f3, input logic [31:0] iadder,
                         input logic [31:0] rs2, input logic req, input logic rdy);
        bus.funct3_in     = f3;
        bus.iadder_in     = iadder;
        bus.rs2_in        = rs2;
        bus.mem_wr_req_in = req;
        bus.ahb_ready_in  = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];
    out_t exp_q;
    out_t sw_exp;

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive(2'b10, 32'hFFFF_FFFF, 32'hCAFE_F00D, 1'b1, 1'b1);

        vecs.push_back('{"sb_off0", 2'b00, 32'h1000, 32'h0000_00A5, 1'b1, '{32'h1000, 32'h0000_00A5, 4'b0001, 2'b10, 1'b1}});
        vecs.push_back('{"sb_off1", 2'b00, 32'h1001, 32'h0000_00A5, 1'b1, '{32'h1000, 32'h0000_A500, 4'b0010, 2'b10, 1'b1}});
        vecs.push_back('{"sb_off2", 2'b00, 32'h1002, 32'h0000_00A5, 1'b1, '{32'h1000, 32'h00A5_0000, 4'b0100, 2'b10, 1'b1}});
        vecs.push_back('{"sb_off3", 2'b00, 32'h1003, 32'h0000_00A5, 1'b1, '{32'h1000, 32'hA500_0000, 4'b1000, 2'b10, 1'b1}});
        vecs.push_back('{"sh_hi",   2'b01, 32'h0002, 32'h0000_FFFF, 1'b1, '{32'h0000, 32'hFFFF_0000, 4'b1100, 2'b10, 1'b1}});
        vecs.push_back('{"sh_lo",   2'b01, 32'h0000, 32'h0000_FFFF, 1'b1, '{32'h0000, 32'h0000_FFFF, 4'b0011, 2'b10, 1'b1}});
        vecs.push_back('{"sh_odd",  2'b01, 32'h0007, 32'h1234_5678, 1'b1, '{32'h0004, 32'h5678_0000, 4'b1100, 2'b10, 1'b1}});
        vecs.push_back('{"sb_upper",2'b00, 32'h0005, 32'hFFFF_FF3C, 1'b1, '{32'h0004, 32'h0000_3C00, 4'b0010, 2'b10, 1'b1}});
        vecs.push_back('{"sw",      2'b10, 32'h0013, 32'hDEAD_BEEF, 1'b1, '{32'h0010, 32'hDEAD_BEEF, 4'b1111, 2'b10, 1'b1}});
        vecs.push_back('{"sw_f3_11",2'b11, 32'h8000_0022, 32'h0BAD_CAFE, 1'b1, '{32'h8000_0020, 32'h0BAD_CAFE, 4'b1111, 2'b10, 1'b1}});
        vecs.push_back('{"idle",    2'b00, 32'h0007, 32'h1234_5678, 1'b0, '{32'h0004, 32'h7800_0000, 4'b1000, 2'b00, 1'b0}});

        // Reset holds everything at zero regardless of inputs and clock edges.
        step();
        check("reset_hold", zero_out());
        step();
        check("reset_hold2", zero_out());
        drive(2'b10, 32'h0000_0013, 32'hDEAD_BEEF, 1'b1, 1'b0);
        #2 rst_n = 1'b1;
        step();
        check("post_reset_not_ready", zero_out());

        foreach (vecs[i]) begin
            drive(vecs[i].f3, vecs[i].iadder, vecs[i].rs2, vecs[i].req, 1'b1);
            step();
            check(vecs[i].name, vecs[i].exp);
        end

        // Stall: outputs freeze while inputs churn with ready low.
        drive(2'b10, 32'h0000_0013, 32'hDEAD_BEEF, 1'b1, 1'b1);
        step();
        sw_exp = '{32'h10, 32'hDEAD_BEEF, 4'b1111, 2'b10, 1'b1};
        check("stall_issue", sw_exp);
        for (int k = 0; k < 3; k++) begin
            drive(2'(k), 32'h0000_2001 + 32'(k), 32'h1111_1111 * 32'(k + 2), k[0], 1'b0);
            step();
            check($sformatf("stall_hold%0d", k), sw_exp);
        end
        drive(2'b00, 32'h0000_3001, 32'h0000_0077, 1'b1, 1'b1);
        step();
        check("stall_release", '{32'h3000, 32'h0000_7700, 4'b0010, 2'b10, 1'b1});

        // Async reset during a stalled request clears it without a clock edge.
        drive(2'b10, 32'h0000_4000, 32'h5555_AAAA, 1'b1, 1'b0);
        step();
        rst_n = 1'b0;
        #1;
        check("async_reset", zero_out());
        step();
        #1 rst_n = 1'b1;
        drive(2'b10, 32'h0000_4000, 32'h5555_AAAA, 1'b1, 1'b1);
        step();
        check("first_edge_after_reset", '{32'h4000, 32'h5555_AAAA, 4'b1111, 2'b10, 1'b1});

        // Randomized traffic with random wait states.
        exp_q = actual();
        exp_q = '{32'h4000, 32'h5555_AAAA, 4'b1111, 2'b10, 1'b1};
        for (int n = 0; n < 400; n++) begin
            logic [1:0]  f3;
            logic [31:0] ia;
            logic [31:0] rs;
            logic        rq;
            logic        rdy;
            f3  = 2'($urandom_range(0, 3));
            ia  = $urandom;
            rs  = $urandom;
            rq  = 1'($urandom_range(0, 1));
            rdy = ($urandom_range(0, 3) != 0);
            drive(f3, ia, rs, rq, rdy);
            if (rdy) exp_q = model(f3, ia, rs, rq);
            step();
            check($sformatf("rand%0d", n), exp_q);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/msrv32_store_unit.md
# msrv32_store_unit

Store path of the msrv32 core's memory stage. It takes the store width (funct3), the effective address from the immediate adder and the rs2 store data. It produces a word-aligned data-bus address, lane-steered write data, a byte write mask and an AHB-Lite address-phase transfer type. All outputs are registered and advance only when the AHB bus signals ready.

## Interface
Parameters: none.
- clk_in  input  1  core clock, rising-edge active
- rst_n_in  input  1  reset, asynchronous, active-low
- funct3_in  input  2  store width: 00 SB, 01 SH, 10/11 SW
- iadder_in  input  32  effective byte address (rs1 + imm)
- rs2_in  input  32  store source data
- mem_wr_req_in  input  1  store request from decode/control
- ahb_ready_in  input  1  AHB HREADY; 1 = bus accepts the address phase
- d_addr_out  output  32  word-aligned address {iadder_in[31:2], 2'b00}
- data_out  output  32  lane-steered write data
- wr_mask_out  output  4  byte-lane write enables, bit n = byte lane n
- ahb_htrans_out  output  2  HTRANS: 2'b10 NONSEQ when a store is issued, 2'b00 IDLE otherwise
- wr_req_out  output  1  registered copy of mem_wr_req_in

## Operation
- Offset is off = iadder_in[1:0].
- SB (00):
  - data_out has rs2_in[7:0] in lane off; all other lanes are 0.
  - wr_mask_out = 4'b0001 << off.
- SH (01):
  - iadder_in[1]=0: data_out = {16'h0, rs2_in[15:0]}, mask 4'b0011.
  - iadder_in[1]=1: data_out = {rs2_in[15:0], 16'h0}, mask 4'b1100.
  - iadder_in[0] is ignored; no misalignment trap is raised in this block.
- SW (10, 11):
  - data_out = rs2_in, wr_mask_out = 4'b1111.
  - iadder_in[1:0] is ignored apart from address alignment.
- When mem_wr_req_in=0, data_out, mask and address are still computed and registered. ahb_htrans_out=IDLE and wr_req_out=0 then mark the cycle as no transfer. Downstream must qualify the mask with wr_req_out.
- ahb_htrans_out = NONSEQ iff the captured mem_wr_req_in was 1, else IDLE.

## Timing
- Reset (rst_n_in=0, asynchronous): all outputs are 0, so d_addr_out=0, data_out=0, wr_mask_out=0, ahb_htrans_out=IDLE, wr_req_out=0. Reset has priority over everything and clears an in-flight stalled request.
- Each rising clk_in edge with ahb_ready_in=1: all outputs load from the current inputs. Latency is 1 cycle.
- Rising edge with ahb_ready_in=0: all outputs hold their previous values. This is an AHB wait state; the address phase must stay stable.
- A request that is pending while ready is low is not lost, because the outputs hold. A new request presented during a stall is dropped unless the control unit keeps it asserted until ready returns.
- Back-to-back stores with ready high issue one per cycle with no bubble.
- The first edge after reset deassertion loads normally.

## Structure
- Shared package msrv32_pkg:
  - funct3 store encodings: SB=2'b00, SH=2'b01, SW=2'b10.
  - HTRANS constants: IDLE=2'b00, NONSEQ=2'b10.
- One combinational sub-module, msrv32_store_align.
  - Inputs: funct3, off, rs2.
  - Outputs: data, mask.
- The top level holds the address alignment and the output register bank with its ready-gated enable.

## Test plan
- Reset and hold: rst_n_in=0 with arbitrary inputs -> all outputs 0 and htrans=00. They stay 0 after release until the first ready edge.
- SB at each offset: rs2=32'h000000A5, funct3=00, iadder=0x1000..0x1003, req=1, ready=1 -> after one edge:
  - d_addr=0x1000.
  - mask = 0001, 0010, 0100, 1000 for the four offsets.
  - data = 0x000000A5, 0x0000A500, 0x00A50000, 0xA5000000.
  - htrans=10, wr_req=1.
- SH: rs2=32'h0000FFFF, funct3=01 -> iadder=0x2 gives mask 1100, data 0xFFFF0000; iadder=0x0 gives mask 0011, data 0x0000FFFF.
- SW: rs2=32'hDEADBEEF, funct3=10, iadder=0x13 -> d_addr=0x10, mask 1111, data 0xDEADBEEF.
- Stall: issue SW with ready=1, then change all inputs with ready=0 for 3 edges -> outputs unchanged. Raise ready -> new values appear on the next edge.
- Idle cycle: req=0, ready=1 -> htrans=00 and wr_req=0 on the next edge. Mask and data follow funct3/iadder.
